// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button front end: button indices and test-button FSM states,
// reused by the tamagotchi FSM and display blocks.
package button_conditioner_pkg;

    localparam int unsigned FEED    = 0;
    localparam int unsigned HEAL    = 1;
    localparam int unsigned TEST    = 2;
    localparam int unsigned NUM_BTN = 3;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_HELD = 2'd1,
        T_LONG = 2'd2
    } test_state_e;

    // Counter width for a cycle budget of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner_btn_debounce.sv
// One button: two-flop synchronizer, stability counter and accepted level.
// rise_o/fall_o flag the cycle in which the accepted level is about to change.
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DebCycles = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW    = cnt_width(DebCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebCycles - 1);

    logic [1:0]      sync_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sample;
    logic            accept;

    assign sample = sync_q[1];
    assign accept = (sample != stable_q) && (cnt_q >= CntLast);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (accept) begin
            stable_d = sample;
            cnt_d    = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset to "released" so leaving reset never looks like a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = accept & sample;
    assign fall_o  = accept & ~sample;

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: debounces feed/heal/test and produces the clean strobes
// and test-mode level consumed by the tamagotchi FSM.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 50000,
    parameter int unsigned LONG_CYCLES    = 250000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       btn_feed_raw,
    input  logic       btn_heal_raw,
    input  logic       btn_test_raw,
    output logic       feeding,
    output logic       healing,
    output logic       testBut,
    output logic       test_step,
    output logic [2:0] btn_level
);

    localparam int unsigned     HoldW    = cnt_width(LONG_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    logic [NUM_BTN-1:0] raw_pressed;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic               unused_fall;

    test_state_e      state_q;
    logic [HoldW-1:0] hold_q;
    logic             feed_q, heal_q, mode_q, step_q;

    assign raw_pressed[FEED] = btn_feed_raw ^ BTN_ACTIVE_LOW;
    assign raw_pressed[HEAL] = btn_heal_raw ^ BTN_ACTIVE_LOW;
    assign raw_pressed[TEST] = btn_test_raw ^ BTN_ACTIVE_LOW;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DebCycles(DEB_CYCLES)
        ) u_deb (
            .clk_i  (Clk),
            .rst_i  (Rst),
            .raw_i  (raw_pressed[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Feed/heal releases carry no meaning.
    assign unused_fall = fall[FEED] ^ fall[HEAL];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= T_IDLE;
            hold_q  <= '0;
            feed_q  <= 1'b0;
            heal_q  <= 1'b0;
            mode_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            feed_q <= rise[FEED];
            heal_q <= rise[HEAL];
            step_q <= 1'b0;
            unique case (state_q)
                T_IDLE: begin
                    if (rise[TEST]) begin
                        hold_q  <= '0;
                        state_q <= T_HELD;
                    end
                end
                T_HELD: begin
                    if (fall[TEST]) begin
                        step_q  <= 1'b1;
                        state_q <= T_IDLE;
                    end else if (hold_q >= HoldLast) begin
                        mode_q  <= ~mode_q;
                        state_q <= T_LONG;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                T_LONG: begin
                    if (fall[TEST]) begin
                        state_q <= T_IDLE;
                    end
                end
                default: state_q <= T_IDLE;
            endcase
        end
    end

    assign feeding   = feed_q;
    assign healing   = heal_q;
    assign testBut   = mode_q;
    assign test_step = step_q;
    assign btn_level = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEB_CYCLES=4, LONG_CYCLES=20, active-low pins.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       btn_feed_raw = 1'b1;
    logic       btn_heal_raw = 1'b1;
    logic       btn_test_raw = 1'b1;
    logic       feeding, healing, testBut, test_step;
    logic [2:0] btn_level;

    int n_vec = 0;
    int n_err = 0;
    int n_feed = 0;
    int n_heal = 0;
    int n_step = 0;
    int n_wide = 0;
    logic [2:0] lvl_seen = 3'b000;
    logic feed_prev = 1'b0, heal_prev = 1'b0, step_prev = 1'b0;

    button_conditioner #(
        .DEB_CYCLES    (4),
        .LONG_CYCLES   (20),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .btn_feed_raw(btn_feed_raw),
        .btn_heal_raw(btn_heal_raw),
        .btn_test_raw(btn_test_raw),
        .feeding     (feeding),
        .healing     (healing),
        .testBut     (testBut),
        .test_step   (test_step),
        .btn_level   (btn_level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally strobes seen there.
    task automatic cycle();
        @(negedge Clk);
        if (feeding) n_feed++;
        if (healing) n_heal++;
        if (test_step) n_step++;
        if ((feeding && feed_prev) || (healing && heal_prev) || (test_step && step_prev)) n_wide++;
        feed_prev = feeding;
        heal_prev = healing;
        step_prev = test_step;
        lvl_seen  = lvl_seen | btn_level;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold the test button for n cycles; report when the level rose and testBut toggled.
    task automatic test_hold(input int n, output int lvl_i, output int tog_i, output int togs);
        logic prev;
        prev  = testBut;
        lvl_i = -1;
        tog_i = -1;
        togs  = 0;
        btn_test_raw = 1'b0;
        for (int i = 1; i <= n; i++) begin
            cycle();
            if (btn_level[2] && lvl_i < 0) lvl_i = i;
            if (testBut != prev) begin
                togs++;
                if (tog_i < 0) tog_i = i;
                prev = testBut;
            end
        end
    endtask

    initial begin
        int first_f, first_h, cnt_f, step0, lvl_i, tog_i, togs;

        // Reset with all pins released.
        #2 Rst = 1'b1;
        cycles(10);
        check("rst_feeding", 32'(feeding), 0);
        check("rst_healing", 32'(healing), 0);
        check("rst_testBut", 32'(testBut), 0);
        check("rst_test_step", 32'(test_step), 0);
        check("rst_btn_level", 32'(btn_level), 0);
        Rst = 1'b0;
        n_feed = 0; n_heal = 0; n_step = 0; lvl_seen = '0;
        cycles(50);
        check("post_rst_strobes", 32'(n_feed + n_heal + n_step), 0);
        check("post_rst_levels", 32'(lvl_seen), 0);

        // Clean feed press: strobe on the 6th edge after the pin falls.
        btn_feed_raw = 1'b0;
        first_f = -1;
        cnt_f   = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (feeding) begin
                cnt_f++;
                if (first_f < 0) first_f = i;
            end
        end
        check("feed_latency", 32'(first_f), 6);
        check("feed_count", 32'(cnt_f), 1);
        check("feed_level", 32'(btn_level[0]), 1);
        btn_feed_raw = 1'b1;
        cycles(20);
        check("feed_release_no_strobe", 32'(n_feed), 1);
        check("feed_level_released", 32'(btn_level[0]), 0);

        // Heal bounce: 2-cycle runs never reach the debounced level.
        lvl_seen = '0;
        for (int i = 0; i < 10; i++) begin
            btn_heal_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        btn_heal_raw = 1'b1;
        cycles(20);
        check("bounce_no_healing", 32'(n_heal), 0);
        check("bounce_level_low", 32'(lvl_seen[1]), 0);

        // Short test press: test_step 6 edges after release.
        btn_test_raw = 1'b0;
        cycles(10);
        btn_test_raw = 1'b1;
        step0 = n_step;
        first_f = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (test_step && first_f < 0) first_f = i;
        end
        check("short_step_latency", 32'(first_f), 6);
        check("short_step_count", 32'(n_step - step0), 1);
        check("short_testBut", 32'(testBut), 0);

        // Two long presses: testBut 0->1 then 1->0, 20 edges after the level rises.
        for (int r = 0; r < 2; r++) begin
            step0 = n_step;
            test_hold(40, lvl_i, tog_i, togs);
            check("long_level_rise", 32'(lvl_i), 6);
            check("long_toggle_at", 32'(tog_i), 26);
            check("long_toggle_once", 32'(togs), 1);
            check("long_testBut", 32'(testBut), (r == 0) ? 1 : 0);
            btn_test_raw = 1'b1;
            cycles(20);
            check("long_no_step", 32'(n_step - step0), 0);
        end

        // Simultaneous feed and heal.
        btn_feed_raw = 1'b0;
        btn_heal_raw = 1'b0;
        first_f = -1;
        first_h = -1;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            if (feeding && first_f < 0) first_f = i;
            if (healing && first_h < 0) first_h = i;
        end
        check("sim_feed_at", 32'(first_f), 6);
        check("sim_heal_at", 32'(first_h), 6);
        btn_feed_raw = 1'b1;
        btn_heal_raw = 1'b1;
        cycles(20);

        // Enter test mode, then reset at hold count 10 of another long press.
        test_hold(40, lvl_i, tog_i, togs);
        btn_test_raw = 1'b1;
        cycles(20);
        check("pre_rst_testBut", 32'(testBut), 1);
        step0 = n_step;
        test_hold(16, lvl_i, tog_i, togs);
        check("midhold_state", 32'(dut.state_q), 32'(T_HELD));
        check("midhold_count", 32'(dut.hold_q), 10);
        Rst = 1'b1;
        #1;
        check("midrst_testBut", 32'(testBut), 0);
        check("midrst_state", 32'(dut.state_q), 32'(T_IDLE));
        check("midrst_level", 32'(btn_level), 0);
        cycles(3);
        Rst = 1'b0;
        lvl_i = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (btn_level[2] && lvl_i < 0) lvl_i = i;
        end
        check("midrst_no_step", 32'(n_step - step0), 0);
        check("held_after_rst_accepted", 32'(lvl_i), 6);
        btn_test_raw = 1'b1;
        cycles(20);
        check("strobes_one_cycle", 32'(n_wide), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
